// File: rtl/usb_rx_bit_decoder.sv
// USB receive front end: bit-timing recovery, NRZI decode, bit-unstuffing
// and SE0/EOP detection, feeding the serial-to-parallel shift register.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        synchronous active-low reset
//   d_plus_sync  synchronized D+ line
//   d_minus_sync synchronized D- line
//   rcving       receive enable; low forces the idle state
//   d_orig       decoded data bit, held between shifts
//   shift_enable one-cycle pulse per valid (non-stuffed) decoded bit
//   byte_done    one-cycle pulse the cycle after the 8th shift of a byte
//   eop          high while the last sampled line state was SE0
//   stuff_err    one-cycle pulse when a stuffed bit position carries a 1
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_OFFSET = 3,
    parameter int STUFF_LEN     = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    input  logic rcving,
    output logic d_orig,
    output logic shift_enable,
    output logic byte_done,
    output logic eop,
    output logic stuff_err
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_LEN + 1);

    localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_SAMPLE = TW'(SAMPLE_OFFSET);
    localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);

    logic [TW-1:0] timer, timer_nxt;
    logic [OW-1:0] ones_cnt, ones_cnt_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic          d_plus_q, d_plus_q_nxt;
    logic          prev_line, prev_line_nxt;
    logic          d_orig_nxt;
    logic          shift_nxt;
    logic          byte_done_nxt;
    logic          eop_nxt;
    logic          stuff_err_nxt;

    logic line_edge;
    logic sample;
    logic se0;
    logic dec_bit;
    logic stuff_pos;

    assign line_edge = d_plus_sync ^ d_plus_q;
    // An edge in the sample cycle wins: the timer resyncs instead.
    assign sample    = (timer == T_SAMPLE) && !line_edge;
    assign se0       = !d_plus_sync && !d_minus_sync;
    // NRZI: no transition decodes as 1.
    assign dec_bit   = ~(d_plus_sync ^ prev_line);
    assign stuff_pos = (ones_cnt == ONES_MAX);

    always_comb begin
        d_plus_q_nxt  = d_plus_sync;
        prev_line_nxt = prev_line;
        ones_cnt_nxt  = ones_cnt;
        bit_cnt_nxt   = bit_cnt;
        d_orig_nxt    = d_orig;
        eop_nxt       = eop;
        shift_nxt     = 1'b0;
        stuff_err_nxt = 1'b0;
        // bit_cnt already holds the post-shift count here, so a shift
        // that left it at 0 was the 8th bit of a byte.
        byte_done_nxt = shift_enable && (bit_cnt == 3'd0);

        if (line_edge || (timer == T_LAST)) begin
            timer_nxt = '0;
        end else begin
            timer_nxt = timer + 1'b1;
        end

        if (sample) begin
            if (se0) begin
                eop_nxt      = 1'b1;
                bit_cnt_nxt  = 3'd0;
                ones_cnt_nxt = '0;
            end else begin
                eop_nxt       = 1'b0;
                prev_line_nxt = d_plus_sync;
                if (stuff_pos) begin
                    stuff_err_nxt = dec_bit;
                    ones_cnt_nxt  = '0;
                end else begin
                    shift_nxt    = 1'b1;
                    d_orig_nxt   = dec_bit;
                    ones_cnt_nxt = dec_bit ? ones_cnt + 1'b1 : '0;
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                end
            end
        end

        if (!rcving) begin
            timer_nxt     = '0;
            d_plus_q_nxt  = 1'b1;
            prev_line_nxt = 1'b1;
            ones_cnt_nxt  = '0;
            bit_cnt_nxt   = 3'd0;
            d_orig_nxt    = 1'b1;
            eop_nxt       = 1'b0;
            shift_nxt     = 1'b0;
            stuff_err_nxt = 1'b0;
            byte_done_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            timer        <= '0;
            d_plus_q     <= 1'b1;
            prev_line    <= 1'b1;
            ones_cnt     <= '0;
            bit_cnt      <= 3'd0;
            d_orig       <= 1'b1;
            shift_enable <= 1'b0;
            byte_done    <= 1'b0;
            eop          <= 1'b0;
            stuff_err    <= 1'b0;
        end else begin
            timer        <= timer_nxt;
            d_plus_q     <= d_plus_q_nxt;
            prev_line    <= prev_line_nxt;
            ones_cnt     <= ones_cnt_nxt;
            bit_cnt      <= bit_cnt_nxt;
            d_orig       <= d_orig_nxt;
            shift_enable <= shift_nxt;
            byte_done    <= byte_done_nxt;
            eop          <= eop_nxt;
            stuff_err    <= stuff_err_nxt;
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Scoreboard testbench for usb_rx_bit_decoder: directed NRZI line stimulus,
// expected output events queued by the stimulus and checked by a monitor.
module tb_usb_rx_bit_decoder;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic d_plus_sync = 1'b1;
    logic d_minus_sync = 1'b0;
    logic rcving = 1'b0;
    logic d_orig, shift_enable, byte_done, eop, stuff_err;

    usb_rx_bit_decoder dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .d_plus_sync (d_plus_sync),
        .d_minus_sync(d_minus_sync),
        .rcving      (rcving),
        .d_orig      (d_orig),
        .shift_enable(shift_enable),
        .byte_done   (byte_done),
        .eop         (eop),
        .stuff_err   (stuff_err)
    );

    always #5 clk = ~clk;

    localparam int EV_SHIFT = 0;
    localparam int EV_SERR  = 1;
    localparam int EV_BD    = 2;
    localparam int EV_EOP_R = 3;
    localparam int EV_EOP_F = 4;

    typedef struct {
        int   kind;
        logic val;
    } ev_t;

    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_se = -1;
    logic mon_en = 1'b0;
    logic eop_prev = 1'b0;
    logic se_prev = 1'b0;
    logic line = 1'b1;

    function automatic string kname(input int k);
        case (k)
            EV_SHIFT: return "shift";
            EV_SERR:  return "stuff_err";
            EV_BD:    return "byte_done";
            EV_EOP_R: return "eop_rise";
            EV_EOP_F: return "eop_fall";
            default:  return "none";
        endcase
    endfunction

    task automatic expect_ev(input int k, input logic v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_shifts(input logic v, input int n);
        for (int i = 0; i < n; i++) expect_ev(EV_SHIFT, v);
    endtask

    task automatic got_ev(input int k, input logic v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event @%0d: got %s (d_orig=%0b), required none",
                     cyc, kname(k), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_SHIFT && e.val !== v)) begin
                n_fail++;
                $display("FAIL event @%0d: got %s (d_orig=%0b), required %s (d_orig=%0b)",
                         cyc, kname(k), v, kname(e.kind), e.val);
            end
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (eop !== eop_prev) got_ev(eop ? EV_EOP_R : EV_EOP_F, 1'b0);
            if (shift_enable) begin
                if (last_se >= 0) begin
                    n_checks++;
                    if (cyc - last_se < 8) begin
                        n_fail++;
                        $display("FAIL shift_gap: got %0d cycles, required >= 8",
                                 cyc - last_se);
                    end
                end
                last_se = cyc;
                got_ev(EV_SHIFT, d_orig);
            end
            if (stuff_err) got_ev(EV_SERR, 1'b0);
            if (byte_done) begin
                got_ev(EV_BD, 1'b0);
                check1("byte_done_after_shift", se_prev, 1'b1);
            end
            if (!rcving) last_se = -1;
        end
        eop_prev = eop;
        se_prev  = shift_enable;
    end

    task automatic send_bit(input logic b, input int per);
        if (!b) line = ~line;
        d_plus_sync  = line;
        d_minus_sync = ~line;
        repeat (per) @(posedge clk);
        #1;
    endtask

    // bits[0] goes on the line first.
    task automatic send_seq(input logic [15:0] bits, input int n, input int per);
        for (int i = 0; i < n; i++) send_bit(bits[i], per);
    endtask

    task automatic send_se0(input int per);
        d_plus_sync  = 1'b0;
        d_minus_sync = 1'b0;
        repeat (per) @(posedge clk);
        #1;
    endtask

    task automatic send_j(input int per);
        line = 1'b1;
        d_plus_sync  = 1'b1;
        d_minus_sync = 1'b0;
        repeat (per) @(posedge clk);
        #1;
    endtask

    task automatic end_pkt(input string name);
        rcving       = 1'b0;
        line         = 1'b1;
        d_plus_sync  = 1'b1;
        d_minus_sync = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d expected events missing, required 0",
                     name, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        // Reset held with the line toggling and rcving high.
        n_rst  = 1'b0;
        rcving = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            d_plus_sync  = ~d_plus_sync;
            d_minus_sync = ~d_plus_sync;
            @(negedge clk);
            check1("rst_d_orig", d_orig, 1'b1);
            check1("rst_shift_enable", shift_enable, 1'b0);
            check1("rst_byte_done", byte_done, 1'b0);
            check1("rst_eop", eop, 1'b0);
            check1("rst_stuff_err", stuff_err, 1'b0);
        end
        @(posedge clk);
        #1;
        rcving       = 1'b0;
        line         = 1'b1;
        d_plus_sync  = 1'b1;
        d_minus_sync = 1'b0;
        n_rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // SYNC: K J K J K J K K
        expect_shifts(1'b0, 7);
        expect_ev(EV_SHIFT, 1'b1);
        expect_ev(EV_BD, 1'b0);
        rcving = 1'b1;
        send_seq(16'b1000_0000, 8, 8);
        end_pkt("sync");

        // SYNC with a 9-clock bit period
        expect_shifts(1'b0, 7);
        expect_ev(EV_SHIFT, 1'b1);
        expect_ev(EV_BD, 1'b0);
        rcving = 1'b1;
        send_seq(16'b1000_0000, 8, 9);
        end_pkt("drift");

        // 0, six 1s, stuffed 0, 1, 1
        expect_ev(EV_SHIFT, 1'b0);
        expect_shifts(1'b1, 7);
        expect_ev(EV_BD, 1'b0);
        expect_ev(EV_SHIFT, 1'b1);
        rcving = 1'b1;
        send_seq(16'b0000_0011_0111_1110, 10, 8);
        end_pkt("stuff");

        // 0 then seven 1s: the seventh sits in the stuffed position
        expect_ev(EV_SHIFT, 1'b0);
        expect_shifts(1'b1, 6);
        expect_ev(EV_SERR, 1'b0);
        rcving = 1'b1;
        send_seq(16'b1111_1110, 8, 8);
        end_pkt("stuff_err");

        // Three bits, SE0 x2, J, then seven more bits
        expect_shifts(1'b0, 3);
        expect_ev(EV_EOP_R, 1'b0);
        expect_ev(EV_EOP_F, 1'b0);
        expect_ev(EV_SHIFT, 1'b0);
        expect_ev(EV_SHIFT, 1'b1);
        expect_ev(EV_SHIFT, 1'b0);
        expect_ev(EV_SHIFT, 1'b1);
        expect_ev(EV_SHIFT, 1'b0);
        expect_ev(EV_SHIFT, 1'b0);
        expect_ev(EV_SHIFT, 1'b1);
        expect_ev(EV_SHIFT, 1'b1);
        expect_ev(EV_BD, 1'b0);
        rcving = 1'b1;
        send_seq(16'b000, 3, 8);
        send_se0(16);
        send_j(8);
        send_seq(16'b110_0101, 7, 8);
        end_pkt("eop");

        // Abort after 4 bits, then a full byte
        expect_shifts(1'b0, 4);
        rcving = 1'b1;
        send_seq(16'b0000, 4, 8);
        end_pkt("abort_partial");
        expect_shifts(1'b0, 7);
        expect_ev(EV_SHIFT, 1'b1);
        expect_ev(EV_BD, 1'b0);
        rcving = 1'b1;
        send_seq(16'b1000_0000, 8, 8);
        end_pkt("abort_next");

        // Reset mid-byte while d_orig holds 0
        expect_shifts(1'b0, 2);
        rcving = 1'b1;
        send_seq(16'b00, 2, 8);
        check1("pre_rst_d_orig", d_orig, 1'b0);
        n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check1("mid_rst_d_orig", d_orig, 1'b1);
        check1("mid_rst_shift_enable", shift_enable, 1'b0);
        check1("mid_rst_eop", eop, 1'b0);
        rcving = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        end_pkt("mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
